// File: rtl/k580_pic_pkg.sv
// rtl/k580_pic_pkg.sv - shared types, constants and priority helper for k580_int_ctrl
// Contents:
//   pic_state_t  - IDLE/REQ/ACK handshake state
//   CMD_*        - bit positions in the a0=0 command byte
//   RST_OPCODE   - RST 0 opcode; the RST number is OR'ed into bits [5:3]
//   prio_enc8    - returns {valid, index} of the first set bit scanning from base upward (mod 8)
package k580_pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } pic_state_t;

  localparam int CMD_EOI   = 5;
  localparam int CMD_SPEC  = 6;
  localparam int CMD_RDSEL = 0;

  localparam logic [7:0] RST_OPCODE = 8'hC7;

  // Scan from the farthest position back to base so the last hit wins,
  // leaving the bit closest to base (the highest priority) in the result.
  function automatic logic [3:0] prio_enc8(input logic [7:0] vec, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/k580_pic_prio.sv
// rtl/k580_pic_prio.sv - combinational 8-bit rotating priority encoder
// Ports:
//   vec   in  8  candidate bits
//   base  in  3  index treated as highest priority
//   valid out 1  any bit of vec set
//   idx   out 3  winning index
module k580_pic_prio
  import k580_pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] base,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    {valid, idx} = prio_enc8(vec, base);
  end

endmodule

// File: rtl/k580_int_ctrl.sv
// rtl/k580_int_ctrl.sv - 8-level priority interrupt controller for the k580wm80a bus
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   ce              clock enable shared with the CPU
//   irq[7:0]        request lines, bit 0 highest (fixed priority)
//   cs, a0          register select and address from the I/O decoder
//   wr_n, rd, din   CPU write strobe (low), read strobe (high), write data
//   dout[7:0]       registered read data
//   inta_n          CPU interrupt-acknowledge strobe, active low
//   intr            interrupt request to the CPU
//   vec_o[7:0]      RST opcode presented during INTA
// Optional build macro: K580_PIC_ROTATE_EN adds rotating priority driven by
// non-specific EOI (register prio, next level after the one ended becomes highest).
module k580_int_ctrl
  import k580_pic_pkg::*;
#(
  parameter logic [2:0] RST_BASE = 3'd0,
  parameter bit         EDGE     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] irq,
  input  logic       cs,
  input  logic       a0,
  input  logic       wr_n,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       inta_n,
  output logic       intr,
  output logic [7:0] vec_o
);

  pic_state_t state, state_n;
  logic [2:0] lvl, lvl_n;
  logic       intr_n;
  logic       ack;

  logic [7:0] irr, isr, imr, irq_prev;
  logic       rdsel;

  logic [2:0] rot_base;

`ifdef K580_PIC_ROTATE_EN
  logic [2:0] prio;
  assign rot_base = prio;
`else
  assign rot_base = 3'd0;
`endif

  // Candidate selection and the in-service gate share one encoder each;
  // the ISR encoder also names the target of a non-specific EOI.
  logic [7:0] pend;
  logic       win_valid, isr_valid;
  logic [2:0] win_idx, isr_top;

  assign pend = irr & ~imr;

  k580_pic_prio u_win_enc (
    .vec   (pend),
    .base  (rot_base),
    .valid (win_valid),
    .idx   (win_idx)
  );

  k580_pic_prio u_isr_enc (
    .vec   (isr),
    .base  (rot_base),
    .valid (isr_valid),
    .idx   (isr_top)
  );

  // Compare in rotated rank space so the gate works for any priority base.
  logic [2:0] win_rank, isr_rank;
  logic       qualify;

  assign win_rank = win_idx - rot_base;
  assign isr_rank = isr_top - rot_base;
  assign qualify  = win_valid && (!isr_valid || (win_rank < isr_rank));

  // Register interface decode
  logic       wr_en, imr_we, cmd_we, eoi, eoi_spec, eoi_valid;
  logic [2:0] eoi_lvl;

  assign wr_en     = cs & ~wr_n;
  assign imr_we    = wr_en & a0;
  assign cmd_we    = wr_en & ~a0;
  assign eoi       = cmd_we & din[CMD_EOI];
  assign eoi_spec  = din[CMD_SPEC];
  assign eoi_valid = eoi & (eoi_spec | isr_valid);
  assign eoi_lvl   = eoi_spec ? din[2:0] : isr_top;

  // Handshake FSM
  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    intr_n  = intr;
    ack     = 1'b0;
    case (state)
      IDLE: begin
        if (qualify) begin
          lvl_n   = win_idx;
          intr_n  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (!inta_n) begin
          ack     = 1'b1;
          intr_n  = 1'b0;
          state_n = ACK;
        end else if (!win_valid) begin
          intr_n  = 1'b0;
          state_n = IDLE;
        end else if (qualify) begin
          lvl_n = win_idx;
        end
      end
      ACK: begin
        if (inta_n) state_n = IDLE;
      end
      default: begin
        intr_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lvl   <= 3'd0;
      intr  <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      lvl   <= lvl_n;
      intr  <= intr_n;
    end
  end

  // Request / in-service next values. The ACK set is applied before an EOI
  // clear so a same-tick EOI cannot cancel the level being acknowledged
  // unless it names it explicitly. A fresh edge on the acknowledged level
  // is OR'ed in after the clear so it is not lost.
  logic [7:0] ack_mask, eoi_mask, irr_n, isr_n;

  assign ack_mask = ack ? (8'b1 << lvl) : 8'h00;
  assign eoi_mask = eoi_valid ? (8'b1 << eoi_lvl) : 8'h00;
  assign irr_n    = EDGE ? ((irr & ~ack_mask) | (irq & ~irq_prev)) : (irq & ~ack_mask);
  assign isr_n    = (isr | ack_mask) & ~eoi_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      irr      <= 8'h00;
      isr      <= 8'h00;
      imr      <= 8'hFF;
      irq_prev <= 8'h00;
      rdsel    <= 1'b0;
      dout     <= 8'h00;
`ifdef K580_PIC_ROTATE_EN
      prio     <= 3'd0;
`endif
    end else if (ce) begin
      irr      <= irr_n;
      isr      <= isr_n;
      irq_prev <= irq;
      if (imr_we) imr <= din;
      if (cmd_we && !din[CMD_EOI]) rdsel <= din[CMD_RDSEL];
      if (cs && rd) dout <= a0 ? imr : (rdsel ? isr : irr);
`ifdef K580_PIC_ROTATE_EN
      if (eoi_valid && !eoi_spec) prio <= eoi_lvl + 3'd1;
`endif
    end
  end

  // lvl only changes outside the INTA tick, so the opcode is stable while sampled.
  logic [2:0] rst_num;
  assign rst_num = lvl + RST_BASE;
  assign vec_o   = RST_OPCODE | {2'b00, rst_num, 3'b000};

endmodule
